// File: rtl/stopwatch_pkg.sv
// Shared state encoding, time field widths and default limits for the stopwatch block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    localparam logic [1:0] SW_MODE = 2'd2;
    localparam int CS_PER_SEC = 100;
    localparam int MAX_MIN    = 59;

    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CSEC_W = 7;

    typedef struct packed {
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [CSEC_W-1:0] csec;
    } sw_time_t;

endpackage

// File: rtl/sw_time_counter.sv
// Cascaded centisecond/second/minute counter; wrap_o strobes for one cycle after a full wrap.
module sw_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CsPerSec = CS_PER_SEC,
    parameter int MaxMin   = MAX_MIN
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [MIN_W-1:0]  min_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [CSEC_W-1:0] csec_o,
    output logic              wrap_o
);

    localparam logic [CSEC_W-1:0] CsLast  = CSEC_W'(CsPerSec - 1);
    localparam logic [SEC_W-1:0]  SecLast = SEC_W'(59);
    localparam logic [MIN_W-1:0]  MinLast = MIN_W'(MaxMin);

    logic [MIN_W-1:0]  min_q,  min_d;
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [CSEC_W-1:0] csec_q, csec_d;
    logic              wrap_q, wrap_d;

    // Clear dominates; each field only advances when all lower fields roll over.
    always_comb begin
        min_d  = min_q;
        sec_d  = sec_q;
        csec_d = csec_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            min_d  = '0;
            sec_d  = '0;
            csec_d = '0;
        end else if (en_i) begin
            if (csec_q == CsLast) begin
                csec_d = '0;
                if (sec_q == SecLast) begin
                    sec_d = '0;
                    if (min_q == MinLast) begin
                        min_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        min_d = min_q + MIN_W'(1);
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end else begin
                csec_d = csec_q + CSEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            min_q  <= '0;
            sec_q  <= '0;
            csec_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            sec_q  <= sec_d;
            csec_q <= csec_d;
            wrap_q <= wrap_d;
        end
    end

    assign min_o  = min_q;
    assign sec_o  = sec_q;
    assign csec_o = csec_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button edge detect, run/pause/lap FSM, lap snapshot and display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CsPerSec = CS_PER_SEC,
    parameter int MaxMin   = MAX_MIN
) (
    input  logic              mili_clk,
    input  logic              reset,
    input  logic [1:0]        currentMode,
    input  logic              tick,
    input  logic              mili_set,
    input  logic              mili_clear,
    input  logic              mili_lap,
    output logic [MIN_W-1:0]  disp_minutes,
    output logic [SEC_W-1:0]  disp_seconds,
    output logic [CSEC_W-1:0] disp_csec,
    output logic              running,
    output logic              lap_active,
    output logic              wrap_pulse
);

    sw_state_e state_q, state_d;
    sw_time_t  snap_q, snap_d, live, dispTime;
    logic      set_q, clr_q, lap_q;
    logic      modeOk, clrSel, setSel, lapSel;
    logic      cntEn, cntClr, wrap;

    // A single winning pulse per cycle: clear beats set beats lap.
    assign modeOk = (currentMode == SW_MODE);
    assign clrSel = modeOk & mili_clear & ~clr_q;
    assign setSel = modeOk & mili_set & ~set_q & ~clrSel;
    assign lapSel = modeOk & mili_lap & ~lap_q & ~clrSel & ~setSel;

    assign cntEn = tick & ((state_q == RUN) | (state_q == LAP));

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cntClr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clrSel) begin
                    cntClr = 1'b1;
                    snap_d = '0;
                end else if (setSel) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (setSel) begin
                    state_d = PAUSE;
                end else if (lapSel) begin
                    state_d = LAP;
                    snap_d  = live;
                end
            end
            LAP: begin
                if (setSel) begin
                    state_d = PAUSE;
                end else if (lapSel) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (setSel) begin
                    state_d = RUN;
                end else if (clrSel) begin
                    state_d = IDLE;
                    cntClr  = 1'b1;
                    snap_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mili_clk) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            set_q   <= 1'b0;
            clr_q   <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            set_q   <= mili_set;
            clr_q   <= mili_clear;
            lap_q   <= mili_lap;
        end
    end

    sw_time_counter #(
        .CsPerSec(CsPerSec),
        .MaxMin  (MaxMin)
    ) u_counter (
        .clk_i  (mili_clk),
        .reset_i(reset),
        .en_i   (cntEn),
        .clr_i  (cntClr),
        .min_o  (live.min),
        .sec_o  (live.sec),
        .csec_o (live.csec),
        .wrap_o (wrap)
    );

    // The lap view is frozen on the snapshot; every other state tracks the live counters.
    assign dispTime     = (state_q == LAP) ? snap_q : live;
    assign disp_minutes = dispTime.min;
    assign disp_seconds = dispTime.sec;
    assign disp_csec    = dispTime.csec;
    assign running      = (state_q == RUN) | (state_q == LAP);
    assign lap_active   = (state_q == LAP);
    assign wrap_pulse   = wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized buttons against a total-centisecond model.
module tb_stopwatch_ctrl;

    localparam int CS     = 100;
    localparam int MM     = 1;
    localparam int PERIOD = (MM + 1) * 60 * CS;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic       mili_clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] currentMode = 2'd2;
    logic       tick = 1'b0;
    logic       mili_set = 1'b0;
    logic       mili_clear = 1'b0;
    logic       mili_lap = 1'b0;
    logic [5:0] disp_minutes;
    logic [5:0] disp_seconds;
    logic [6:0] disp_csec;
    logic       running;
    logic       lap_active;
    logic       wrap_pulse;

    int  testsRun = 0;
    int  testsFailed = 0;
    bit  checkEn = 1'b0;

    int  mState = S_IDLE;
    int  mT = 0;
    int  mSnap = 0;
    int  oldT;
    int  dispT;
    bit  mWrap = 1'b0;
    bit  mSetH, mClrH, mLapH;
    bit  modeOk, pClr, pSet, pLap;

    stopwatch_ctrl #(
        .CsPerSec(CS),
        .MaxMin  (MM)
    ) dut (
        .mili_clk    (mili_clk),
        .reset       (reset),
        .currentMode (currentMode),
        .tick        (tick),
        .mili_set    (mili_set),
        .mili_clear  (mili_clear),
        .mili_lap    (mili_lap),
        .disp_minutes(disp_minutes),
        .disp_seconds(disp_seconds),
        .disp_csec   (disp_csec),
        .running     (running),
        .lap_active  (lap_active),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 mili_clk = ~mili_clk;

    // Reference model: time is one integer of centiseconds, split only for display.
    always @(posedge mili_clk) begin
        if (reset) begin
            mState = S_IDLE;
            mT     = 0;
            mSnap  = 0;
            mWrap  = 1'b0;
            mSetH  = 1'b0;
            mClrH  = 1'b0;
            mLapH  = 1'b0;
        end else begin
            modeOk = (currentMode == 2'd2);
            pClr   = modeOk && mili_clear && !mClrH;
            pSet   = modeOk && mili_set && !mSetH && !pClr;
            pLap   = modeOk && mili_lap && !mLapH && !pClr && !pSet;
            oldT   = mT;
            mWrap  = 1'b0;
            if (tick && (mState == S_RUN || mState == S_LAP)) begin
                if (mT == PERIOD - 1) begin
                    mT    = 0;
                    mWrap = 1'b1;
                end else begin
                    mT = mT + 1;
                end
            end
            case (mState)
                S_IDLE:  if (pClr) begin mT = 0; mSnap = 0; end
                         else if (pSet) mState = S_RUN;
                S_RUN:   if (pSet) mState = S_PAUSE;
                         else if (pLap) begin mState = S_LAP; mSnap = oldT; end
                S_LAP:   if (pSet) mState = S_PAUSE;
                         else if (pLap) mState = S_RUN;
                default: if (pSet) mState = S_RUN;
                         else if (pClr) begin mState = S_IDLE; mT = 0; mSnap = 0; end
            endcase
            mSetH = mili_set;
            mClrH = mili_clear;
            mLapH = mili_lap;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle after reset the DUT must match the model.
    always @(negedge mili_clk) begin
        if (checkEn) begin
            dispT = (mState == S_LAP) ? mSnap : mT;
            checkOutput("disp_minutes", 32'(disp_minutes), 32'(dispT / (60 * CS)));
            checkOutput("disp_seconds", 32'(disp_seconds), 32'((dispT / CS) % 60));
            checkOutput("disp_csec", 32'(disp_csec), 32'(dispT % CS));
            checkOutput("running", 32'(running), 32'(mState == S_RUN || mState == S_LAP));
            checkOutput("lap_active", 32'(lap_active), 32'(mState == S_LAP));
            checkOutput("wrap_pulse", 32'(wrap_pulse), 32'(mWrap));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge mili_clk);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        cycles(n);
        tick = 1'b0;
    endtask

    task automatic applyStimulus(input bit s, input bit c, input bit l);
        mili_set   = s;
        mili_clear = c;
        mili_lap   = l;
        cycles(1);
        mili_set   = 1'b0;
        mili_clear = 1'b0;
        mili_lap   = 1'b0;
        cycles(1);
    endtask

    task automatic checkTime(input string name, input int mn, input int sc, input int cs);
        checkOutput({name, "_min"}, 32'(disp_minutes), 32'(mn));
        checkOutput({name, "_sec"}, 32'(disp_seconds), 32'(sc));
        checkOutput({name, "_csec"}, 32'(disp_csec), 32'(cs));
    endtask

    initial begin
        cycles(2);
        checkEn = 1'b1;
        cycles(1);
        checkTime("reset", 0, 0, 0);
        checkOutput("reset_running", 32'(running), 32'd0);
        reset = 1'b0;
        cycles(1);

        applyStimulus(1, 0, 0);
        ticks(150);
        checkTime("t1", 0, 1, 50);
        checkOutput("t1_running", 32'(running), 32'd1);
        checkOutput("t1_model", 32'(mT), 32'd150);

        ticks(175);
        applyStimulus(0, 0, 1);
        ticks(40);
        checkTime("t2_hold", 0, 3, 25);
        checkOutput("t2_lap_active", 32'(lap_active), 32'd1);
        applyStimulus(0, 0, 1);
        checkTime("t2_live", 0, 3, 65);
        checkOutput("t2_model", 32'(mT), 32'd365);

        ticks(335);
        applyStimulus(1, 0, 0);
        ticks(50);
        checkTime("t3_pause", 0, 7, 0);
        checkOutput("t3_running", 32'(running), 32'd0);
        applyStimulus(0, 1, 0);
        checkTime("t3_clear", 0, 0, 0);

        currentMode = 2'd1;
        mili_set = 1'b1;
        cycles(2);
        currentMode = 2'd2;
        cycles(3);
        mili_set = 1'b0;
        ticks(5);
        checkOutput("t4_running", 32'(running), 32'd0);
        checkTime("t4", 0, 0, 0);

        applyStimulus(1, 0, 0);
        ticks(20);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        checkTime("t5_all", 0, 0, 0);
        checkOutput("t5_all_running", 32'(running), 32'd0);
        applyStimulus(1, 0, 0);
        ticks(10);
        applyStimulus(1, 0, 1);
        checkOutput("t5_setlap_lap", 32'(lap_active), 32'd0);
        checkOutput("t5_setlap_running", 32'(running), 32'd0);
        checkOutput("t5_setlap_csec", 32'(disp_csec), 32'd10);
        applyStimulus(0, 1, 0);

        applyStimulus(1, 0, 0);
        ticks(PERIOD - 2);
        checkTime("t6_pre", MM, 59, 98);
        ticks(1);
        checkTime("t6_last", MM, 59, 99);
        ticks(1);
        checkTime("t6_wrap", 0, 0, 0);
        checkOutput("t6_wrap_pulse", 32'(wrap_pulse), 32'd1);
        cycles(1);
        checkOutput("t6_wrap_end", 32'(wrap_pulse), 32'd0);
        ticks(30);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        checkTime("t6_reset", 0, 0, 0);
        checkOutput("t6_reset_running", 32'(running), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) mili_set = ~mili_set;
            if ($urandom_range(0, 9) == 0) mili_clear = ~mili_clear;
            if ($urandom_range(0, 6) == 0) mili_lap = ~mili_lap;
            if ($urandom_range(0, 63) == 0) currentMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) currentMode = 2'd2;
            reset = ($urandom_range(0, 999) == 0);
            cycles(1);
        end
        reset = 1'b0;
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
